// File: rtl/matrix_loader.sv
// Builds two matrices from a word stream: header words set R1/C1/R2/C2, element words fill m1 then m2 row-major.
// One word is consumed on every CLK edge with no backpressure; all outputs are registered except the combinational rd_data.
module matrix_loader #(
  parameter int DW      = 4,
  parameter int MAX_DIM = 4,
  localparam int IW     = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [DW-1:0] data_send,
  input  logic          ctrl_logic,
  input  logic          rd_mat,
  input  logic [IW-1:0] rd_row,
  input  logic [IW-1:0] rd_col,
  output logic [DW-1:0] rd_data,
  output logic [DW-1:0] R1,
  output logic [DW-1:0] C1,
  output logic [DW-1:0] R2,
  output logic [DW-1:0] C2,
  output logic          loaded1,
  output logic          loaded2,
  output logic          size_err
);

  typedef enum logic [1:0] {HDR, LOAD1, LOAD2, DONE} state_t;

  state_t        state;
  logic [1:0]    hdr_idx;
  logic [IW-1:0] row;
  logic [IW-1:0] col;
  logic [DW-1:0] m1 [MAX_DIM][MAX_DIM];
  logic [DW-1:0] m2 [MAX_DIM][MAX_DIM];

  logic [DW-1:0] cur_r;
  logic [DW-1:0] cur_c;
  logic          col_last;
  logic          row_last;
  logic          new_frame;
  logic          hdr_bad;

  function automatic logic dim_bad(input logic [DW-1:0] d);
    return (d == '0) || (32'(d) > 32'(MAX_DIM));
  endfunction

  assign cur_r    = (state == LOAD2) ? R2 : R1;
  assign cur_c    = (state == LOAD2) ? C2 : C1;
  assign col_last = (DW'(col) + DW'(1)) == cur_c;
  assign row_last = (DW'(row) + DW'(1)) == cur_r;
  // Any header word outside HDR restarts the frame; it is always taken as R1.
  assign new_frame = ctrl_logic && ((state != HDR) || (hdr_idx == 2'd0));
  // C2 is checked straight from the bus since it is being captured this cycle.
  assign hdr_bad   = dim_bad(R1) || dim_bad(C1) || dim_bad(R2) || dim_bad(data_send);

  assign rd_data = rd_mat ? m2[rd_row][rd_col] : m1[rd_row][rd_col];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= HDR;
      hdr_idx  <= 2'd0;
      row      <= '0;
      col      <= '0;
      R1       <= '0;
      C1       <= '0;
      R2       <= '0;
      C2       <= '0;
      loaded1  <= 1'b0;
      loaded2  <= 1'b0;
      size_err <= 1'b0;
      for (int i = 0; i < MAX_DIM; i++) begin
        for (int j = 0; j < MAX_DIM; j++) begin
          m1[i][j] <= '0;
          m2[i][j] <= '0;
        end
      end
    end else if (new_frame) begin
      state    <= HDR;
      hdr_idx  <= 2'd1;
      row      <= '0;
      col      <= '0;
      R1       <= data_send;
      loaded1  <= 1'b0;
      loaded2  <= 1'b0;
      size_err <= 1'b0;
      for (int i = 0; i < MAX_DIM; i++) begin
        for (int j = 0; j < MAX_DIM; j++) begin
          m1[i][j] <= '0;
          m2[i][j] <= '0;
        end
      end
    end else begin
      case (state)
        HDR: begin
          if (ctrl_logic) begin
            case (hdr_idx)
              2'd1: begin
                C1      <= data_send;
                hdr_idx <= 2'd2;
              end
              2'd2: begin
                R2      <= data_send;
                hdr_idx <= 2'd3;
              end
              default: begin
                C2      <= data_send;
                hdr_idx <= 2'd0;
                if (hdr_bad) begin
                  size_err <= 1'b1;
                  state    <= DONE;
                end else begin
                  state    <= LOAD1;
                end
              end
            endcase
          end
        end
        LOAD1, LOAD2: begin
          if (state == LOAD1) m1[row][col] <= data_send;
          else                m2[row][col] <= data_send;
          if (col_last) begin
            col <= '0;
            if (row_last) begin
              row <= '0;
              if (state == LOAD1) begin
                loaded1 <= 1'b1;
                state   <= LOAD2;
              end else begin
                loaded2 <= 1'b1;
                state   <= DONE;
              end
            end else begin
              row <= row + IW'(1);
            end
          end else begin
            col <= col + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_loader.sv
// Directed and random stream stimulus for matrix_loader, checked word by word against a frame-level model.
module tb_matrix_loader;
  localparam int DW = 4;
  localparam int MD = 4;
  localparam int IW = 2;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [DW-1:0] data_send = '0;
  logic          ctrl_logic = 1'b0;
  logic          rd_mat = 1'b0;
  logic [IW-1:0] rd_row = '0;
  logic [IW-1:0] rd_col = '0;
  logic [DW-1:0] rd_data, R1, C1, R2, C2;
  logic          loaded1, loaded2, size_err;

  int tests = 0;
  int fails = 0;

  matrix_loader #(.DW(DW), .MAX_DIM(MD)) dut (
    .CLK(CLK), .RST_N(RST_N), .data_send(data_send), .ctrl_logic(ctrl_logic),
    .rd_mat(rd_mat), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
    .R1(R1), .C1(C1), .R2(R2), .C2(C2),
    .loaded1(loaded1), .loaded2(loaded2), .size_err(size_err)
  );

  always #50 CLK = ~CLK;

  // Model: header words seen in the current frame, element count, and expected contents.
  int         dims [4];
  int         hcnt;
  int         n;
  bit         bad;
  logic [3:0] em1 [4][4];
  logic [3:0] em2 [4][4];

  function automatic void clear_mats();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        em1[r][c] = '0;
        em2[r][c] = '0;
      end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) dims[i] = 0;
    clear_mats();
    hcnt = 0;
    n    = 0;
    bad  = 0;
  endfunction

  function automatic void model_word(input bit c, input int d);
    int p1, p2;
    if (c) begin
      if (hcnt == 0 || hcnt == 4) begin
        hcnt = 0;
        n    = 0;
        bad  = 0;
        clear_mats();
      end
      dims[hcnt] = d;
      hcnt++;
      if (hcnt == 4)
        for (int i = 0; i < 4; i++) if (dims[i] == 0 || dims[i] > MD) bad = 1;
    end else if (hcnt == 4 && !bad) begin
      p1 = dims[0] * dims[1];
      p2 = dims[2] * dims[3];
      if (n < p1) em1[n / dims[1]][n % dims[1]] = 4'(d);
      else if (n < p1 + p2) em2[(n - p1) / dims[3]][(n - p1) % dims[3]] = 4'(d);
      if (n < p1 + p2) n++;
    end
  endfunction

  function automatic bit exp_l1();
    return hcnt == 4 && !bad && n >= dims[0] * dims[1];
  endfunction

  function automatic bit exp_l2();
    return hcnt == 4 && !bad && n >= dims[0] * dims[1] + dims[2] * dims[3];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input bit m, input int r, input int c, input int exp);
    rd_mat = m;
    rd_row = IW'(r);
    rd_col = IW'(c);
    #1;
    chk(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":R1"}, 32'(R1), 32'(dims[0]));
    chk({tag, ":C1"}, 32'(C1), 32'(dims[1]));
    chk({tag, ":R2"}, 32'(R2), 32'(dims[2]));
    chk({tag, ":C2"}, 32'(C2), 32'(dims[3]));
    chk({tag, ":loaded1"}, 32'(loaded1), 32'(exp_l1()));
    chk({tag, ":loaded2"}, 32'(loaded2), 32'(exp_l2()));
    chk({tag, ":size_err"}, 32'(size_err), 32'(hcnt == 4 && bad));
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        chk_rd($sformatf("%s:m1[%0d][%0d]", tag, r, c), 1'b0, r, c, int'(em1[r][c]));
        chk_rd($sformatf("%s:m2[%0d][%0d]", tag, r, c), 1'b1, r, c, int'(em2[r][c]));
      end
  endtask

  // Inputs change on the falling edge; everything is checked shortly after the rising edge.
  task automatic send(input bit c, input int d, input string tag);
    @(negedge CLK);
    ctrl_logic = c;
    data_send  = 4'(d);
    @(posedge CLK);
    model_word(c, d);
    #1;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    #120;
    check_all("reset");
    @(negedge CLK);
    RST_N = 1'b1;

    // Partial first frame.
    send(1, 2, "t1h"); send(1, 3, "t1h"); send(1, 2, "t1h"); send(1, 1, "t1h");
    send(0, 0, "t1e"); send(0, 9, "t1e"); send(0, 7, "t1e"); send(0, 4, "t1e");
    chk_rd("t1_m1_01", 1'b0, 0, 1, 9);
    chk_rd("t1_m1_10", 1'b0, 1, 0, 4);
    chk("t1_loaded1", 32'(loaded1), 32'd0);

    // Full 2x2 + 2x2 frame with an extra element after completion.
    send(1, 2, "t2h"); send(1, 2, "t2h"); send(1, 2, "t2h"); send(1, 2, "t2h");
    for (int i = 1; i <= 9; i++) begin
      send(0, i, "t2e");
      if (i == 3) chk("t2_loaded1_early", 32'(loaded1), 32'd0);
      if (i == 4) chk("t2_loaded1", 32'(loaded1), 32'd1);
      if (i == 7) chk("t2_loaded2_early", 32'(loaded2), 32'd0);
    end
    chk("t2_loaded2", 32'(loaded2), 32'd1);
    chk_rd("t2_m2_11", 1'b1, 1, 1, 8);

    // Oversized dimension.
    send(1, 5, "t3h"); send(1, 2, "t3h"); send(1, 1, "t3h"); send(1, 1, "t3h");
    chk("t3_size_err", 32'(size_err), 32'd1);
    send(0, 6, "t3e"); send(0, 6, "t3e");
    chk_rd("t3_m1_00", 1'b0, 0, 0, 0);

    // Abort a partial load with a new header.
    send(1, 2, "t4h"); send(1, 2, "t4h"); send(1, 1, "t4h"); send(1, 1, "t4h");
    send(0, 3, "t4e"); send(0, 3, "t4e");
    send(1, 1, "t4h2"); send(1, 1, "t4h2"); send(1, 1, "t4h2"); send(1, 1, "t4h2");
    send(0, 6, "t4e2"); send(0, 7, "t4e2");
    chk_rd("t4_m1_00", 1'b0, 0, 0, 6);
    chk_rd("t4_m2_00", 1'b1, 0, 0, 7);
    chk_rd("t4_m1_01", 1'b0, 0, 1, 0);

    // Element word inside the header is ignored.
    send(1, 2, "t5h"); send(1, 1, "t5h"); send(0, 9, "t5x"); send(1, 1, "t5h"); send(1, 1, "t5h");
    send(0, 5, "t5e"); send(0, 10, "t5e"); send(0, 12, "t5e");
    chk("t5_loaded2", 32'(loaded2), 32'd1);

    // Asynchronous reset in the middle of LOAD1.
    send(1, 2, "t6h"); send(1, 2, "t6h"); send(1, 1, "t6h"); send(1, 1, "t6h");
    send(0, 3, "t6e"); send(0, 3, "t6e");
    #5;
    RST_N = 1'b0;
    #1;
    model_reset();
    check_all("t6_async_rst");
    @(negedge CLK);
    ctrl_logic = 1'b0;
    data_send  = '0;
    RST_N      = 1'b1;
    send(0, 5, "t6_idle");
    send(1, 1, "t6h2"); send(1, 2, "t6h2"); send(1, 1, "t6h2"); send(1, 1, "t6h2");
    send(0, 11, "t6e2"); send(0, 13, "t6e2"); send(0, 14, "t6e2");

    // Random stream.
    for (int k = 0; k < 300; k++) begin
      bit c;
      int d;
      c = ($urandom_range(0, 4) == 0);
      if (c) d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 4));
      else   d = int'($urandom_range(0, 15));
      send(c, d, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end
endmodule
